sap8_board: RTL and testbench

// - Top level of a SAP-1 style 8-bit computer: 16x8 RAM, 4-bit MAR and PC, 8-bit IR, A, B and OUT registers.
// - Also holds an adder/subtractor, carry/zero flags and a microcoded controller, all sharing one 8-bit internal bus.
// - A program mode lets an external loader write RAM through the bus.
// - Run mode fetches and executes from address 0 and shows results on `display`.

---
 rtl/sap8_board.sv | 219 +++++++++++++++++++++
 tb/tb_sap8_board.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sap8_board.sv
// SAP-1 style 8-bit computer: 16x8 RAM, PC/MAR/IR/A/B/OUT, flags and a microcoded controller on one internal bus.
// Every instruction takes 5 clocks (T0..T4). pmode=1 freezes the CPU and gives the loader the RAM, and HLT freezes the CPU until clr.
module sap8_board (
  input  logic       clk,
  input  logic       clr,
  input  logic       pmode,
  input  logic       ramwa,
  input  logic       ramoa,
  input  logic [3:0] prog_addr,
  inout  wire  [7:0] Bus,
  output logic [7:0] display
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;
  typedef enum logic [2:0] {SRC_NONE, SRC_PC, SRC_RAM, SRC_IR, SRC_A, SRC_ALU} src_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [7:0] mem [16];
  logic [3:0] pc;
  logic [3:0] mar;
  logic [7:0] ir;
  logic [7:0] a;
  logic [7:0] b;
  logic       cf;
  logic       zf;
  logic       halt;

  step_t step;
  step_t step_nxt;
  src_t  src;

  logic ld_mar;
  logic ld_ir;
  logic inc_pc;
  logic ld_pc;
  logic ld_a;
  logic ld_b;
  logic ld_out;
  logic ld_flags;
  logic ram_we;
  logic set_halt;

  logic [3:0] opcode;
  logic       sub;
  logic [8:0] alu;
  logic [7:0] bus_int;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       run_en;

  assign opcode = ir[7:4];
  assign sub    = (opcode == OP_SUB);
  // Subtraction is A + ~B + 1, so alu[8] is the carry out (1 = no borrow).
  assign alu    = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {8'h00, sub};
  assign run_en = !pmode && !halt;

  always_comb begin
    bus_int = 8'h00;
    case (src)
      SRC_PC:  bus_int = {4'h0, pc};
      SRC_RAM: bus_int = mem[mar];
      SRC_IR:  bus_int = {4'h0, ir[3:0]};
      SRC_A:   bus_int = a;
      SRC_ALU: bus_int = alu[7:0];
      default: bus_int = 8'h00;
    endcase
  end

  assign bus_out = pmode ? mem[prog_addr] : bus_int;
  assign bus_oe  = !pmode || ramoa;
  assign Bus     = bus_oe ? bus_out : 8'hzz;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      step <= T0;
    end else if (run_en) begin
      step <= step_nxt;
    end
  end

  always_comb begin
    step_nxt = T0;
    src      = SRC_NONE;
    ld_mar   = 1'b0;
    ld_ir    = 1'b0;
    inc_pc   = 1'b0;
    ld_pc    = 1'b0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_out   = 1'b0;
    ld_flags = 1'b0;
    ram_we   = 1'b0;
    set_halt = 1'b0;
    case (step)
      T0: begin
        step_nxt = T1;
        src      = SRC_PC;
        ld_mar   = 1'b1;
      end
      T1: begin
        step_nxt = T2;
        src      = SRC_RAM;
        ld_ir    = 1'b1;
        inc_pc   = 1'b1;
      end
      T2: begin
        step_nxt = T3;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            src    = SRC_IR;
            ld_mar = 1'b1;
          end
          OP_LDI: begin
            src  = SRC_IR;
            ld_a = 1'b1;
          end
          OP_JMP: begin
            src   = SRC_IR;
            ld_pc = 1'b1;
          end
          OP_JC: begin
            if (cf) begin
              src   = SRC_IR;
              ld_pc = 1'b1;
            end
          end
          OP_JZ: begin
            if (zf) begin
              src   = SRC_IR;
              ld_pc = 1'b1;
            end
          end
          OP_OUT: begin
            src    = SRC_A;
            ld_out = 1'b1;
          end
          OP_HLT:  set_halt = 1'b1;
          default: ;
        endcase
      end
      T3: begin
        step_nxt = T4;
        case (opcode)
          OP_LDA: begin
            src  = SRC_RAM;
            ld_a = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            src  = SRC_RAM;
            ld_b = 1'b1;
          end
          OP_STA: begin
            src    = SRC_A;
            ram_we = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        step_nxt = T0;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          src      = SRC_ALU;
          ld_a     = 1'b1;
          ld_flags = 1'b1;
        end
      end
      default: step_nxt = T0;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc      <= 4'h0;
      mar     <= 4'h0;
      ir      <= 8'h00;
      a       <= 8'h00;
      b       <= 8'h00;
      display <= 8'h00;
      cf      <= 1'b0;
      zf      <= 1'b0;
      halt    <= 1'b0;
    end else if (pmode) begin
      mar <= prog_addr;
    end else if (!halt) begin
      if (ld_mar)   mar     <= bus_int[3:0];
      if (ld_ir)    ir      <= bus_int;
      if (ld_pc)    pc      <= bus_int[3:0];
      else if (inc_pc) pc   <= pc + 4'h1;
      if (ld_a)     a       <= bus_int;
      if (ld_b)     b       <= bus_int;
      if (ld_out)   display <= bus_int;
      if (ld_flags) begin
        cf <= alu[8];
        zf <= (alu[7:0] == 8'h00);
      end
      if (set_halt) halt    <= 1'b1;
    end
  end

  // RAM has no reset so a loaded program survives clr.
  always_ff @(posedge clk) begin
    if (pmode && ramwa) begin
      mem[prog_addr] <= Bus;
    end else if (run_en && ram_we) begin
      mem[mar] <= bus_int;
    end
  end

endmodule

// File: tb/tb_sap8_board.sv
// Directed bench for sap8_board: loads programs through program mode and checks display, Bus and RAM readback.
module tb_sap8_board;

  logic       clk;
  logic       clr;
  logic       pmode;
  logic       ramwa;
  logic       ramoa;
  logic [3:0] prog_addr;
  logic [7:0] display;
  logic       tb_oe;
  logic [7:0] tb_dat;
  wire  [7:0] Bus;

  int checks;
  int errors;

  logic [7:0] img [16];
  logic [7:0] loop_exp [8];

  assign Bus = tb_oe ? tb_dat : 8'hzz;

  sap8_board dut (
    .clk       (clk),
    .clr       (clr),
    .pmode     (pmode),
    .ramwa     (ramwa),
    .ramoa     (ramoa),
    .prog_addr (prog_addr),
    .Bus       (Bus),
    .display   (display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %02h want %02h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    pmode = 1'b1;
    clr   = 1'b1;
    @(negedge clk);
    clr   = 1'b0;
  endtask

  task automatic write_ram(input logic [3:0] addr, input logic [7:0] dat);
    pmode     = 1'b1;
    prog_addr = addr;
    tb_dat    = dat;
    tb_oe     = 1'b1;
    ramwa     = 1'b1;
    @(negedge clk);
    ramwa     = 1'b0;
    tb_oe     = 1'b0;
  endtask

  task automatic load_img();
    for (int i = 0; i < 16; i++) begin
      write_ram(i[3:0], img[i]);
    end
  endtask

  task automatic check_ram(input string tag, input logic [3:0] addr, input logic [7:0] exp);
    pmode     = 1'b1;
    tb_oe     = 1'b0;
    prog_addr = addr;
    ramoa     = 1'b1;
    #1;
    check(tag, Bus, exp);
    ramoa     = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) begin
      img[i] = 8'h00;
    end
  endtask

  // A-B with flag markers: RAM[0] = 2 if JC taken else 1, RAM[1] = 4 if JZ taken else 3.
  task automatic run_sub(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] res, input logic [7:0] cfm, input logic [7:0] zfm);
    do_reset();
    clear_img();
    img[0]  = 8'h1E; img[1]  = 8'h3F; img[2]  = 8'hE0; img[3]  = 8'h76;
    img[4]  = 8'h51; img[5]  = 8'h67; img[6]  = 8'h52; img[7]  = 8'h40;
    img[8]  = 8'h8B; img[9]  = 8'h53; img[10] = 8'h6C; img[11] = 8'h54;
    img[12] = 8'h41; img[13] = 8'hF0; img[14] = av;    img[15] = bv;
    load_img();
    @(negedge clk);
    pmode = 1'b0;
    tick(13);
    check($sformatf("%s_out", tag), display, res);
    tick(150);
    check($sformatf("%s_hold", tag), display, res);
    check_ram($sformatf("%s_cf", tag), 4'h0, cfm);
    check_ram($sformatf("%s_zf", tag), 4'h1, zfm);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    clr       = 1'b1;
    pmode     = 1'b1;
    ramwa     = 1'b0;
    ramoa     = 1'b0;
    prog_addr = 4'h0;
    tb_oe     = 1'b0;
    tb_dat    = 8'h00;
    loop_exp  = '{8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h80, 8'h00};

    tick(2);
    clr = 1'b0;
    check("rst_display", display, 8'h00);

    clear_img();
    img[0]  = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
    img[14] = 8'h38; img[15] = 8'h23;
    load_img();
    check_ram("rb_0", 4'h0, 8'h1E);
    check_ram("rb_f", 4'hF, 8'h23);

    // Board must not drive: any contribution from RAM[E]=38 would show up.
    @(negedge clk);
    prog_addr = 4'hE;
    ramoa     = 1'b0;
    tb_oe     = 1'b1;
    tb_dat    = 8'h00;
    #1 check("hiz_00", Bus, 8'h00);
    tb_dat = 8'h5A;
    #1 check("hiz_5a", Bus, 8'h5A);
    tb_oe  = 1'b0;
    check_ram("rb_e", 4'hE, 8'h38);

    @(negedge clk);
    do_reset();
    check_ram("ram_kept", 4'h0, 8'h1E);

    @(negedge clk);
    pmode = 1'b0;
    #1 check("t0_bus_pc", Bus, 8'h00);
    tick(1);
    check("t1_bus_ram", Bus, 8'h1E);
    tick(11);
    check("pre_out", display, 8'h00);
    tick(1);
    check("out_5b", display, 8'h5B);
    tick(100);
    check("halt_hold", display, 8'h5B);

    clr = 1'b1;
    #1 check("async_clr", display, 8'h00);
    @(negedge clk);
    clr = 1'b0;
    tick(8);
    clr = 1'b1;
    #1 check("abort_bus", Bus, 8'h00);
    @(negedge clk);
    clr = 1'b0;
    tick(12);
    check("rerun_pre", display, 8'h00);
    tick(1);
    check("rerun_5b", display, 8'h5B);

    run_sub("sub_pos", 8'h38, 8'h23, 8'h15, 8'h02, 8'h03);
    run_sub("sub_neg", 8'h23, 8'h38, 8'hEB, 8'h01, 8'h03);
    run_sub("sub_eq",  8'h47, 8'h47, 8'h00, 8'h02, 8'h04);

    // LDI 3; STA F; ADD F; OUT; JMP 1 -> A doubles each 20-clock pass.
    do_reset();
    clear_img();
    img[0] = 8'h53; img[1] = 8'h4F; img[2] = 8'h2F; img[3] = 8'hE0; img[4] = 8'h61;
    load_img();
    @(negedge clk);
    pmode = 1'b0;
    tick(17);
    check("loop_pre", display, 8'h00);
    tick(1);
    check("loop_0", display, loop_exp[0]);
    for (int k = 1; k < 8; k++) begin
      tick(20);
      check($sformatf("loop_%0d", k), display, loop_exp[k]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
